// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and immediate-type encodings for the immediate
// generator pipeline (imm_decode_comb, imm_gen_pipe).
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_CSR   = 3'd7
    } imm_type_e;

    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SRX);
    endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RV immediate decoder. Define IMM_GEN_ZICSR_EN to decode the
// SYSTEM-opcode CSR immediate forms (uimm in [19:15], type CSR).
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instruction,
    output logic [XLEN-1:0] o_immediate,
    output logic [2:0]      o_imm_type,
    output logic            o_illegal
);

    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_shamt;
    logic [XLEN-1:0] imm_shamt_w;
    imm_type_e       imm_type;

    assign opcode = i_instruction[6:0];
    assign funct3 = i_instruction[14:12];

    assign imm_i       = XLEN'($signed(i_instruction[31:20]));
    assign imm_s       = XLEN'($signed({i_instruction[31:25], i_instruction[11:7]}));
    assign imm_b       = XLEN'($signed({i_instruction[31], i_instruction[7],
                                        i_instruction[30:25], i_instruction[11:8], 1'b0}));
    assign imm_u       = XLEN'($signed({i_instruction[31:12], 12'b0}));
    assign imm_j       = XLEN'($signed({i_instruction[31], i_instruction[19:12],
                                        i_instruction[20], i_instruction[30:21], 1'b0}));
    assign imm_shamt   = XLEN'(i_instruction[20 +: SHAMT_W]);
    assign imm_shamt_w = XLEN'(i_instruction[24:20]);

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        o_immediate = '0;
        imm_type    = IMM_NONE;
        o_illegal   = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                o_immediate = imm_i;
                imm_type    = IMM_I;
            end
            OPC_OP_IMM: begin
                if (is_shift(funct3)) begin
                    o_immediate = imm_shamt;
                    imm_type    = IMM_SHAMT;
                    // shamt[5] only exists on RV64
                    o_illegal   = (XLEN == 32) && i_instruction[25];
                end else begin
                    o_immediate = imm_i;
                    imm_type    = IMM_I;
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    if (is_shift(funct3)) begin
                        o_immediate = imm_shamt_w;
                        imm_type    = IMM_SHAMT;
                    end else begin
                        o_immediate = imm_i;
                        imm_type    = IMM_I;
                    end
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                o_immediate = imm_s;
                imm_type    = IMM_S;
            end
            OPC_BRANCH: begin
                o_immediate = imm_b;
                imm_type    = IMM_B;
            end
            OPC_JAL: begin
                o_immediate = imm_j;
                imm_type    = IMM_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                o_immediate = imm_u;
                imm_type    = IMM_U;
            end
            OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                if (funct3[2]) begin
                    o_immediate = XLEN'(i_instruction[19:15]);
                    imm_type    = IMM_CSR;
                end
`endif
            end
            default: begin
                o_illegal = (i_instruction[1:0] != 2'b11);
            end
        endcase
    end

    assign o_imm_type = imm_type;

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: input-side decode followed by a 2-entry skid buffer
// (output + skid register). CSR decode is enabled by IMM_GEN_ZICSR_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instruction,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_immediate,
    output logic [2:0]       o_imm_type,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       imm_type;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;
    logic            dec_illegal;

    imm_decode_comb #(.XLEN(XLEN)) u_decode (
        .i_instruction(i_instruction),
        .o_immediate  (dec_imm),
        .o_imm_type   (dec_type),
        .o_illegal    (dec_illegal)
    );

    entry_t in_entry;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   ready_q, ready_d;
    logic   in_xfer;
    logic   out_xfer;

    assign in_entry = '{imm: dec_imm, imm_type: dec_type, illegal: dec_illegal, tag: i_tag};
    assign in_xfer  = i_valid && ready_q;
    assign out_xfer = out_valid_q && i_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_xfer) begin
            // Output slot frees up: refill from skid first to keep order.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                out_d       = in_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            // NOTE: only the output payload is reset since it is visible on the ports; the skid payload is always qualified by skid_valid_q.
            out_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            out_q        <= out_d;
        end
    end

    always_ff @(posedge i_clk) begin
        skid_q <= skid_d;
    end

    assign o_ready     = ready_q;
    assign o_valid     = out_valid_q;
    assign o_immediate = out_q.imm;
    assign o_imm_type  = out_q.imm_type;
    assign o_illegal   = out_q.illegal;
    assign o_tag       = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share
// stimulus; honours IMM_GEN_ZICSR_EN for the CSR expectations.
module tb_imm_gen_pipe;

    localparam int TAG_W = 4;

`ifdef IMM_GEN_ZICSR_EN
    localparam logic [63:0] CSR_IMM  = 64'd5;
    localparam logic [2:0]  CSR_TYPE = 3'd7;
    localparam bit          ZICSR    = 1'b1;
`else
    localparam logic [63:0] CSR_IMM  = 64'd0;
    localparam logic [2:0]  CSR_TYPE = 3'd0;
    localparam bit          ZICSR    = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             dn_ready;
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;

    logic             rdy32, vld32, ill32;
    logic [31:0]      imm32;
    logic [2:0]       typ32;
    logic [TAG_W-1:0] tag32;
    logic             rdy64, vld64, ill64;
    logic [63:0]      imm64;
    logic [2:0]       typ64;
    logic [TAG_W-1:0] tag64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(rdy32),
        .i_instruction(instr), .i_tag(tag), .o_valid(vld32), .i_ready(dn_ready),
        .o_immediate(imm32), .o_imm_type(typ32), .o_illegal(ill32), .o_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(rdy64),
        .i_instruction(instr), .i_tag(tag), .o_valid(vld64), .i_ready(dn_ready),
        .o_immediate(imm64), .o_imm_type(typ64), .o_illegal(ill64), .o_tag(tag64)
    );

    typedef struct { logic [63:0] imm; logic [2:0] typ; logic ill; } exp_t;
    typedef struct { logic [31:0] ins; logic [TAG_W-1:0] tag; } word_t;
    typedef struct {
        logic [31:0] ins; logic [TAG_W-1:0] tag;
        logic [63:0] imm32; logic [2:0] typ32; logic ill32;
        logic [63:0] imm64; logic [2:0] typ64; logic ill64;
    } vec_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    vec_t   vecs[$];
    word_t  q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
        logic [63:0] mask;
        mask = (64'd1 << bits) - 64'd1;
        v    = v & mask;
        if (((v >> (bits - 1)) & 64'd1) != 0) v = v | ~mask;
        return v;
    endfunction

    // Reference decode straight from the ISA field layout, using shifts and masks.
    function automatic exp_t ref_decode(input logic [31:0] ins, input bit rv64);
        exp_t        r;
        logic [63:0] x;
        int          f3;
        x  = {32'h0, ins};
        f3 = int'((x >> 12) & 64'd7);
        r  = '{imm: 64'd0, typ: 3'd0, ill: 1'b0};
        case (ins[6:0])
            7'h03, 7'h67: begin r.imm = sext(x >> 20, 12); r.typ = 3'd1; end
            7'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    r.imm = (x >> 20) & (rv64 ? 64'd63 : 64'd31);
                    r.typ = 3'd6;
                    r.ill = !rv64 && (((x >> 25) & 64'd1) != 0);
                end else begin
                    r.imm = sext(x >> 20, 12); r.typ = 3'd1;
                end
            end
            7'h1B: begin
                if (!rv64) r.ill = 1'b1;
                else if (f3 == 1 || f3 == 5) begin r.imm = (x >> 20) & 64'd31; r.typ = 3'd6; end
                else begin r.imm = sext(x >> 20, 12); r.typ = 3'd1; end
            end
            7'h23: begin r.imm = sext(((x >> 25) << 5) | ((x >> 7) & 64'd31), 12); r.typ = 3'd2; end
            7'h63: begin
                r.imm = sext((((x >> 31) & 64'd1) << 12) | (((x >> 7) & 64'd1) << 11) |
                             (((x >> 25) & 64'd63) << 5) | (((x >> 8) & 64'd15) << 1), 13);
                r.typ = 3'd3;
            end
            7'h6F: begin
                r.imm = sext((((x >> 31) & 64'd1) << 20) | (((x >> 12) & 64'd255) << 12) |
                             (((x >> 20) & 64'd1) << 11) | (((x >> 21) & 64'd1023) << 1), 21);
                r.typ = 3'd5;
            end
            7'h37, 7'h17: begin r.imm = sext(x & 64'hFFFF_F000, 32); r.typ = 3'd4; end
            7'h73: begin
                if (ZICSR && f3 >= 4) begin r.imm = (x >> 15) & 64'd31; r.typ = 3'd7; end
            end
            default: r.ill = ((x & 64'd3) != 64'd3);
        endcase
        if (!rv64) r.imm = r.imm & 64'hFFFF_FFFF;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  opc;
        r = $urandom;
        case ($urandom_range(0, 11))
            0: opc = 7'h03;  1: opc = 7'h13;  2: opc = 7'h1B;  3: opc = 7'h67;
            4: opc = 7'h23;  5: opc = 7'h63;  6: opc = 7'h6F;  7: opc = 7'h37;
            8: opc = 7'h17;  9: opc = 7'h73;  10: opc = 7'h33;
            default: return r;
        endcase
        return {r[31:7], opc};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [TAG_W-1:0] t,
                         input logic rdy, input logic fl);
        in_valid = v; instr = ins; tag = t; dn_ready = rdy; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string nm, input logic ev, input logic er);
        check({nm, " o_valid32"}, 64'(vld32), 64'(ev));
        check({nm, " o_ready32"}, 64'(rdy32), 64'(er));
        check({nm, " o_valid64"}, 64'(vld64), 64'(ev));
        check({nm, " o_ready64"}, 64'(rdy64), 64'(er));
    endtask

    task automatic check_word(input string nm, input word_t w);
        exp_t e32, e64;
        e32 = ref_decode(w.ins, 1'b0);
        e64 = ref_decode(w.ins, 1'b1);
        check({nm, " imm32"}, 64'(imm32), e32.imm);
        check({nm, " type32"}, 64'(typ32), 64'(e32.typ));
        check({nm, " illegal32"}, 64'(ill32), 64'(e32.ill));
        check({nm, " tag32"}, 64'(tag32), 64'(w.tag));
        check({nm, " imm64"}, imm64, e64.imm);
        check({nm, " type64"}, 64'(typ64), 64'(e64.typ));
        check({nm, " illegal64"}, 64'(ill64), 64'(e64.ill));
        check({nm, " tag64"}, 64'(tag64), 64'(w.tag));
    endtask

    task automatic check_reset_outputs(input string nm);
        check_state(nm, 1'b0, 1'b1);
        check({nm, " imm32"}, 64'(imm32), 64'd0);
        check({nm, " imm64"}, imm64, 64'd0);
        check({nm, " type"}, 64'({typ32, typ64}), 64'd0);
        check({nm, " illegal"}, 64'({ill32, ill64}), 64'd0);
        check({nm, " tag"}, 64'({tag32, tag64}), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w0, w1, w2;
        logic  in_x, out_x;

        vecs.push_back('{32'hFFF00093, 4'd1,  64'hFFFF_FFFF, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0});
        vecs.push_back('{32'h800000B7, 4'd2,  64'h8000_0000, 3'd4, 1'b0, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0});
        vecs.push_back('{32'h01F09093, 4'd3,  64'h1F,        3'd6, 1'b0, 64'h1F,                  3'd6, 1'b0});
        vecs.push_back('{32'h4010D093, 4'd4,  64'h1,         3'd6, 1'b0, 64'h1,                   3'd6, 1'b0});
        vecs.push_back('{32'h0200D093, 4'd5,  64'h0,         3'd6, 1'b1, 64'h20,                  3'd6, 1'b0});
        vecs.push_back('{32'hFE000EE3, 4'd6,  64'hFFFF_FFFC, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0});
        vecs.push_back('{32'h3002D073, 4'd7,  CSR_IMM,       CSR_TYPE, 1'b0, CSR_IMM,             CSR_TYPE, 1'b0});
        vecs.push_back('{32'h00000001, 4'd8,  64'h0,         3'd0, 1'b1, 64'h0,                   3'd0, 1'b1});
        vecs.push_back('{32'hFE20AC23, 4'd9,  64'hFFFF_FFF8, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0});
        vecs.push_back('{32'h800000EF, 4'd10, 64'hFFF0_0000, 3'd5, 1'b0, 64'hFFFF_FFFF_FFF0_0000, 3'd5, 1'b0});
        vecs.push_back('{32'hFFF0809B, 4'd11, 64'h0,         3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0});
        vecs.push_back('{32'h01F0909B, 4'd12, 64'h0,         3'd0, 1'b1, 64'h1F,                  3'd6, 1'b0});
        vecs.push_back('{32'h12345017, 4'd13, 64'h1234_5000, 3'd4, 1'b0, 64'h1234_5000,           3'd4, 1'b0});
        vecs.push_back('{32'h002081B3, 4'd14, 64'h0,         3'd0, 1'b0, 64'h0,                   3'd0, 1'b0});
        vecs.push_back('{32'h00000073, 4'd15, 64'h0,         3'd0, 1'b0, 64'h0,                   3'd0, 1'b0});
        vecs.push_back('{32'hFFC4A303, 4'd0,  64'hFFFF_FFFC, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0});

        // Reset with an instruction offered: nothing may be captured.
        rst = 1'b1;
        drive(1'b1, 32'hFFF00093, 4'd5, 1'b1, 1'b1);
        repeat (2) next_cycle();
        rst = 1'b0;
        drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check_reset_outputs("reset");

        foreach (vecs[i]) begin
            next_cycle();
            drive(1'b1, vecs[i].ins, vecs[i].tag, 1'b1, 1'b0);
            next_cycle();
            drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d o_valid", i), 64'({vld32, vld64}), 64'd3);
            check($sformatf("vec%0d imm32", i), 64'(imm32), vecs[i].imm32);
            check($sformatf("vec%0d type32", i), 64'(typ32), 64'(vecs[i].typ32));
            check($sformatf("vec%0d illegal32", i), 64'(ill32), 64'(vecs[i].ill32));
            check($sformatf("vec%0d tag32", i), 64'(tag32), 64'(vecs[i].tag));
            check($sformatf("vec%0d imm64", i), imm64, vecs[i].imm64);
            check($sformatf("vec%0d type64", i), 64'(typ64), 64'(vecs[i].typ64));
            check($sformatf("vec%0d illegal64", i), 64'(ill64), 64'(vecs[i].ill64));
            check($sformatf("vec%0d tag64", i), 64'(tag64), 64'(vecs[i].tag));
        end

        // Backpressure: three back-to-back words against a stalled sink.
        w0 = '{32'h00100093, 4'd1};
        w1 = '{32'h00200093, 4'd2};
        w2 = '{32'h00300093, 4'd3};
        next_cycle(); drive(1'b1, w0.ins, w0.tag, 1'b0, 1'b0);
        @(negedge clk); check_state("bp0", 1'b0, 1'b1);
        next_cycle(); drive(1'b1, w1.ins, w1.tag, 1'b0, 1'b0);
        @(negedge clk); check_state("bp1", 1'b1, 1'b1); check_word("bp1", w0);
        next_cycle(); drive(1'b1, w2.ins, w2.tag, 1'b0, 1'b0);
        @(negedge clk); check_state("bp2", 1'b1, 1'b0); check_word("bp2", w0);
        next_cycle(); drive(1'b1, w2.ins, w2.tag, 1'b1, 1'b0);
        @(negedge clk); check_state("bp3", 1'b1, 1'b0); check_word("bp3", w0);
        next_cycle();
        @(negedge clk); check_state("bp4", 1'b1, 1'b1); check_word("bp4", w1);
        next_cycle(); drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
        @(negedge clk); check_state("bp5", 1'b1, 1'b1); check_word("bp5", w2);
        next_cycle();
        @(negedge clk); check_state("bp6", 1'b0, 1'b1);

        // Flush with both entries full and an input offered.
        next_cycle(); drive(1'b1, w0.ins, 4'd4, 1'b0, 1'b0);
        @(negedge clk); check_state("fl0", 1'b0, 1'b1);
        next_cycle(); drive(1'b1, w1.ins, 4'd5, 1'b0, 1'b0);
        @(negedge clk); check_state("fl1", 1'b1, 1'b1);
        next_cycle(); drive(1'b1, w2.ins, 4'd6, 1'b0, 1'b1);
        @(negedge clk); check_state("fl2", 1'b1, 1'b0);
        next_cycle(); drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check_state($sformatf("fl_after%0d", k), 1'b0, 1'b1);
            next_cycle();
        end

        // Flush while o_ready=1: the word offered in the same cycle is discarded.
        drive(1'b1, w0.ins, 4'd7, 1'b0, 1'b0);
        @(negedge clk); check_state("fr0", 1'b0, 1'b1);
        next_cycle(); drive(1'b1, w1.ins, 4'd8, 1'b1, 1'b1);
        @(negedge clk); check_state("fr1", 1'b1, 1'b1);
        next_cycle(); drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
        @(negedge clk); check_state("fr2", 1'b0, 1'b1);
        next_cycle();
        @(negedge clk); check_state("fr3", 1'b0, 1'b1);

        // Reset mid-transfer dominates flush and valid.
        next_cycle(); drive(1'b1, w0.ins, 4'd9, 1'b0, 1'b0);
        next_cycle(); drive(1'b1, w1.ins, 4'd10, 1'b0, 1'b0);
        next_cycle(); drive(1'b1, 32'hFFF00093, 4'd11, 1'b1, 1'b1); rst = 1'b1;
        next_cycle(); rst = 1'b0; drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
        @(negedge clk); check_reset_outputs("rst_mid");

        // Randomised traffic against a queue-based model of the 2-entry buffer.
        q.delete();
        next_cycle();
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 3) != 0), rand_instr(), TAG_W'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
            @(negedge clk);
            check_state($sformatf("rnd%0d", c), q.size() > 0, q.size() < 2);
            if (q.size() > 0) check_word($sformatf("rnd%0d", c), q[0]);
            in_x  = in_valid && (q.size() < 2);
            out_x = (q.size() > 0) && dn_ready;
            next_cycle();
            if (flush) begin
                q.delete();
            end else begin
                if (out_x) void'(q.pop_front());
                if (in_x) q.push_back('{instr, tag});
            end
        end

        drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
